reg_access_seq: RTL

- Multi-cycle initiator that drives the register bank's read, write, PC and CPSR ports for one data-processing operation at a time.
- Per accepted request it reads Rn and Rm (or uses an immediate) and presents the operands to the ALU.
- It then writes the ALU result and flags back, and advances the PC.
- Sits between the instruction decoder (request side) and the register bank and ALU.

---
 rtl/reg_access_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/reg_access_seq.sv
// Multi-cycle register-bank initiator for one data-processing operation at a time:
// reads operands, hands them to the ALU, writes back result/flags and advances the PC.
module reg_access_seq #(
    parameter logic [31:0] PC_STEP = 32'd4,
    parameter int          IMM_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_rd,
    input  logic [3:0]       req_rn,
    input  logic [3:0]       req_rm,
    input  logic             req_use_rm,
    input  logic [IMM_W-1:0] req_imm,
    input  logic             req_wb,
    input  logic             req_set_flags,
    output logic [3:0]       rb_read_A_select,
    output logic [3:0]       rb_read_B_select,
    output logic             rb_read_B_en,
    input  logic [31:0]      rb_read_A_data,
    input  logic [31:0]      rb_read_B_data,
    input  logic [31:0]      rb_read_pc_data,
    output logic [3:0]       rb_write_select,
    output logic             rb_write_en,
    output logic [31:0]      rb_write_data,
    output logic             rb_write_pc_en,
    output logic [31:0]      rb_write_pc_data,
    output logic             rb_write_cpsr_en,
    output logic [3:0]       rb_write_cpsr_data,
    output logic [31:0]      alu_op_a,
    output logic [31:0]      alu_op_b,
    output logic             alu_valid,
    input  logic             alu_done,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_flags,
    output logic             done,
    output logic             busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPT, S_EXEC, S_WB, S_PCINC, S_DONE
    } state_t;

    state_t             state_q;
    logic [3:0]         rd_q;
    logic               use_rm_q;
    logic [IMM_W-1:0]   imm_q;
    logic               wb_q;
    logic               set_flags_q;
    logic [31:0]        pc_q;

    logic [3:0]         a_sel_q, b_sel_q, w_sel_q;
    logic               b_en_q, w_en_q, pc_en_q, cpsr_en_q;
    logic [31:0]        w_data_q, pc_data_q, op_a_q, op_b_q;
    logic [3:0]         cpsr_data_q;
    logic               alu_valid_q, done_q;

    assign req_ready          = (state_q == S_IDLE);
    assign busy               = (state_q != S_IDLE);
    assign rb_read_A_select   = a_sel_q;
    assign rb_read_B_select   = b_sel_q;
    assign rb_read_B_en       = b_en_q;
    assign rb_write_select    = w_sel_q;
    assign rb_write_en        = w_en_q;
    assign rb_write_data      = w_data_q;
    assign rb_write_pc_en     = pc_en_q;
    assign rb_write_pc_data   = pc_data_q;
    assign rb_write_cpsr_en   = cpsr_en_q;
    assign rb_write_cpsr_data = cpsr_data_q;
    assign alu_op_a           = op_a_q;
    assign alu_op_b           = op_b_q;
    assign alu_valid          = alu_valid_q;
    assign done               = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_q        <= '0;
            use_rm_q    <= 1'b0;
            imm_q       <= '0;
            wb_q        <= 1'b0;
            set_flags_q <= 1'b0;
            pc_q        <= '0;
            a_sel_q     <= '0;
            b_sel_q     <= '0;
            w_sel_q     <= '0;
            b_en_q      <= 1'b0;
            w_en_q      <= 1'b0;
            pc_en_q     <= 1'b0;
            cpsr_en_q   <= 1'b0;
            w_data_q    <= '0;
            pc_data_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cpsr_data_q <= '0;
            alu_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        rd_q        <= req_rd;
                        use_rm_q    <= req_use_rm;
                        imm_q       <= req_imm;
                        wb_q        <= req_wb;
                        set_flags_q <= req_set_flags;
                        a_sel_q     <= req_rn;
                        b_sel_q     <= req_rm;
                        b_en_q      <= req_use_rm;
                        state_q     <= S_READ;
                    end
                end
                S_READ: state_q <= S_CAPT;
                S_CAPT: begin
                    // The B bus floats when disabled, so it is only sampled for Rm operands.
                    op_a_q      <= rb_read_A_data;
                    op_b_q      <= use_rm_q ? rb_read_B_data : 32'(imm_q);
                    pc_q        <= rb_read_pc_data;
                    b_en_q      <= 1'b0;
                    alu_valid_q <= 1'b1;
                    state_q     <= S_EXEC;
                end
                S_EXEC: begin
                    if (alu_done) begin
                        alu_valid_q <= 1'b0;
                        w_sel_q     <= rd_q;
                        w_en_q      <= wb_q;
                        w_data_q    <= alu_result;
                        cpsr_en_q   <= set_flags_q;
                        cpsr_data_q <= alu_flags;
                        state_q     <= S_WB;
                    end
                end
                S_WB: begin
                    w_en_q    <= 1'b0;
                    cpsr_en_q <= 1'b0;
                    // A write to R15 is itself the new PC; the increment is skipped.
                    if (wb_q && rd_q == 4'd15) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        pc_en_q   <= 1'b1;
                        pc_data_q <= pc_q + PC_STEP;
                        state_q   <= S_PCINC;
                    end
                end
                S_PCINC: begin
                    pc_en_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
